pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IMC pipeline. It detects load-use hazards, taken-branch redirects and multi-cycle divide occupancy, then drives the hold and bubble controls of the IF/ID, ID/EXE and EXE/MEM pipeline registers. A small FSM with a down-counter keeps EXE occupied for the divide latency while MEM receives bubbles.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // RUN: normal flow, DIV: divide occupies EXE, DONE: one-cycle result handoff
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_CYCLES_DEFAULT = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID source matching a pending load destination.
// Latency: purely combinational, zero cycles.
// Backpressure: none; consumers decide how to stall on load_use.
// Ports: id_rs1/id_rs2 + *_used (ID sources), exe_rd/exe_is_load (EXE producer),
//        load_use (hazard present this cycle).
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] exe_rd,
    input  logic       exe_is_load,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign rs1_match = id_rs1_used && (id_rs1 == exe_rd);
    assign rs2_match = id_rs2_used && (id_rs2 == exe_rd);
    assign load_use  = exe_is_load && (exe_rd != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID, ID/EXE and EXE/MEM: load-use, taken branch, divide occupancy.
// Latency: controls are Mealy (same cycle); div_busy is registered; divide holds EXE DIV_CYCLES+1 cycles.
// Backpressure: if_hold/id_hold freeze upstream stages; bubbles/flushes zero the affected registers.
// Ports: clk, rst (async active-high), ID source fields, EXE producer flags,
//        hold/flush/bubble controls, divider start/done pulses, div_busy.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] exe_rd,
    input  logic       exe_is_load,
    input  logic       exe_is_div,
    input  logic       exe_br_taken,
    output logic       if_hold,
    output logic       id_hold,
    output logic       if_id_flush,
    output logic       id_exe_bubble,
    output logic       exe_mem_bubble,
    output logic       div_start,
    output logic       div_done,
    output logic       div_busy
);

    localparam int CW = $clog2(DIV_CYCLES);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          load_use;

    logic if_hold_c, id_hold_c, if_id_flush_c, id_exe_bubble_c;
    logic exe_mem_bubble_c, div_start_c, div_done_c;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .exe_rd      (exe_rd),
        .exe_is_load (exe_is_load),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            div_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            div_busy <= (state_nxt == ST_DIV);
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        if_hold_c        = 1'b0;
        id_hold_c        = 1'b0;
        if_id_flush_c    = 1'b0;
        id_exe_bubble_c  = 1'b0;
        exe_mem_bubble_c = 1'b0;
        div_start_c      = 1'b0;
        div_done_c       = 1'b0;
        case (state)
            ST_RUN: begin
                if (exe_br_taken) begin
                    // redirect wins: the instructions behind the branch are dead anyway
                    if_id_flush_c   = 1'b1;
                    id_exe_bubble_c = 1'b1;
                end else if (exe_is_div) begin
                    div_start_c      = 1'b1;
                    if_hold_c        = 1'b1;
                    id_hold_c        = 1'b1;
                    exe_mem_bubble_c = 1'b1;
                    // start cycle counts as the first of DIV_CYCLES, DONE follows cnt==0
                    cnt_nxt          = CW'(DIV_CYCLES - 2);
                    state_nxt        = ST_DIV;
                end else if (load_use) begin
                    if_hold_c       = 1'b1;
                    id_exe_bubble_c = 1'b1;
                end
            end
            ST_DIV: begin
                if_hold_c        = 1'b1;
                id_hold_c        = 1'b1;
                exe_mem_bubble_c = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                // exe_is_div still reflects the finishing divide; do not restart on it
                div_done_c = 1'b1;
                state_nxt  = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // reset must silence the pipeline controls immediately, not at the next edge
    assign if_hold        = if_hold_c        && !rst;
    assign id_hold        = id_hold_c        && !rst;
    assign if_id_flush    = if_id_flush_c    && !rst;
    assign id_exe_bubble  = id_exe_bubble_c  && !rst;
    assign exe_mem_bubble = exe_mem_bubble_c && !rst;
    assign div_start      = div_start_c      && !rst;
    assign div_done       = div_done_c       && !rst;

    // a single decoded instruction cannot be both a divide and a branch/load
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(exe_is_div && (exe_br_taken || exe_is_load)));
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with DIV_CYCLES=4.
// Directed literal cases plus randomized traffic compared every cycle against a
// cycle-count model of divide occupancy and the hazard priority rules.
module tb_pipe_hazard_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, exe_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       exe_is_load = 1'b0, exe_is_div = 1'b0, exe_br_taken = 1'b0;
    logic       if_hold, id_hold, if_id_flush, id_exe_bubble;
    logic       exe_mem_bubble, div_start, div_done, div_busy;

    int checks   = 0;
    int failures = 0;

    // model: -1 when no divide in flight, else cycles elapsed since div_start (1..D)
    int         div_cyc = -1;
    logic [7:0] exp_v;
    logic [7:0] outv;

    pipe_hazard_ctrl #(.DIV_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .exe_rd         (exe_rd),
        .exe_is_load    (exe_is_load),
        .exe_is_div     (exe_is_div),
        .exe_br_taken   (exe_br_taken),
        .if_hold        (if_hold),
        .id_hold        (id_hold),
        .if_id_flush    (if_id_flush),
        .id_exe_bubble  (id_exe_bubble),
        .exe_mem_bubble (exe_mem_bubble),
        .div_start      (div_start),
        .div_done       (div_done),
        .div_busy       (div_busy)
    );

    always #10 clk = ~clk;

    // {if_hold, id_hold, if_id_flush, id_exe_bubble, exe_mem_bubble, div_start, div_done, div_busy}
    assign outv = {if_hold, id_hold, if_id_flush, id_exe_bubble,
                   exe_mem_bubble, div_start, div_done, div_busy};

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    function automatic logic hazard_m();
        logic hit;
        hit = 1'b0;
        if (exe_is_load && exe_rd != 5'd0) begin
            if (id_rs1_used && id_rs1 == exe_rd) hit = 1'b1;
            if (id_rs2_used && id_rs2 == exe_rd) hit = 1'b1;
        end
        return hit;
    endfunction

    // per-cycle compare, inputs stable (driven at negedge), before the next rising edge
    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_v   = 8'b0;
        end else if (div_cyc < 0) begin
            if (exe_br_taken)    exp_v = 8'b0011_0000;
            else if (exe_is_div) exp_v = 8'b1100_1100;
            else if (hazard_m()) exp_v = 8'b1001_0000;
            else                 exp_v = 8'b0000_0000;
        end else if (div_cyc < D) begin
            exp_v = 8'b1100_1001;
        end else begin
            exp_v = 8'b0000_0010;
        end
        chk("model", outv, exp_v);
        if (rst)                                      div_cyc = -1;
        else if (div_cyc < 0)                         div_cyc = (!exe_br_taken && exe_is_div) ? 1 : -1;
        else if (div_cyc < D)                         div_cyc = div_cyc + 1;
        else                                          div_cyc = -1;
    end

    task automatic drive(input logic br, input logic dv, input logic ld, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        @(negedge clk);
        exe_br_taken = br;
        exe_is_div   = dv;
        exe_is_load  = ld;
        exe_rd       = rd;
        id_rs1       = r1;
        id_rs2       = r2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
    endtask

    initial begin
        // reset state, with a branch request that must be masked
        exe_br_taken = 1'b1;
        #12;
        chk("reset_outputs", outv, 8'b0);
        @(negedge clk);
        rst = 1'b0;
        exe_br_taken = 1'b0;

        // load-use: one bubble, then clear once EXE holds the bubble
        drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1); #2 chk("load_use", outv, 8'b1001_0000);
        drive(0, 0, 0, 5'd0, 5'd1, 5'd5, 1, 1); #2 chk("load_use_after", outv, 8'b0);
        // x0 destination and unused source never stall
        drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1); #2 chk("load_x0", outv, 8'b0);
        drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 0); #2 chk("load_unused", outv, 8'b0);
        drive(0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0); #2 chk("load_rs1", outv, 8'b1001_0000);
        // branch overrides load-use
        drive(1, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1); #2 chk("branch_wins", outv, 8'b0011_0000);

        // single divide with exe_is_div held through DONE
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("div_c0", outv, 8'b1100_1100);
        for (int c = 1; c < D; c++) begin
            drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("div_mid", outv, 8'b1100_1001);
        end
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("div_done", outv, 8'b0000_0010);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); #2 chk("div_after", outv, 8'b0);

        // back-to-back divides: second start right after first done
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("b2b_start1", outv, 8'b1100_1100);
        for (int c = 1; c < D; c++) drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0);
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("b2b_done1", outv, 8'b0000_0010);
        drive(0, 1, 0, 5'd4, 5'd0, 5'd0, 0, 0); #2 chk("b2b_start2", outv, 8'b1100_1100);
        for (int c = 1; c < D; c++) drive(0, 1, 0, 5'd4, 5'd0, 5'd0, 0, 0);
        drive(0, 1, 0, 5'd4, 5'd0, 5'd0, 0, 0); #2 chk("b2b_done2", outv, 8'b0000_0010);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

        // asynchronous reset in cycle 2 of a divide
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0);
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0);
        drive(0, 1, 0, 5'd3, 5'd0, 5'd0, 0, 0); #2 chk("rst_div_c2", outv, 8'b1100_1001);
        #3 rst = 1'b1;
        #1 chk("rst_async", outv, 8'b0);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        rst = 1'b0;
        #2 chk("run_after_rst", outv, 8'b0);
        drive(0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0); #2 chk("load_after_rst", outv, 8'b1001_0000);

        // randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(7) == 0) begin
                exe_is_div   = 1'b1;
                exe_br_taken = 1'b0;
                exe_is_load  = 1'b0;
            end else begin
                exe_is_div   = 1'b0;
                exe_br_taken = ($urandom_range(5) == 0);
                exe_is_load  = ($urandom_range(2) == 0);
            end
            exe_rd      = 5'($urandom_range(3));
            id_rs1      = 5'($urandom_range(3));
            id_rs2      = 5'($urandom_range(3));
            id_rs1_used = 1'($urandom_range(1));
            id_rs2_used = 1'($urandom_range(1));
        end
        @(negedge clk);
        rst = 1'b0;
        exe_is_div = 1'b0;
        exe_br_taken = 1'b0;
        exe_is_load = 1'b0;
        repeat (D + 3) @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
